// File: rtl/fabric_bringup_seq.sv
// fabric_bringup_seq: fabric/MSS reset sequencer that qualifies PLL lock, releases the MSS,
// then enables user fabric logic; re-sequences on lock loss or MSS reset, latches MSS timeout.
module fabric_bringup_seq #(
    parameter int SYNC_STAGES        = 2,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int MSS_TIMEOUT_CYCLES = 65536
) (
    input  logic       clkin,
    input  logic       resetn,
    input  logic       device_init_done,
    input  logic       pll_lock,
    input  logic       mss_reset_n_m2f,
    output logic       mss_reset_n_f2m,
    output logic       fabric_resetn,
    output logic       enable,
    output logic [2:0] state,
    output logic       fault,
    output logic [7:0] relock_count
);

    localparam logic [2:0] S_INIT   = 3'd0;
    localparam logic [2:0] S_LOCK   = 3'd1;
    localparam logic [2:0] S_STABLE = 3'd2;
    localparam logic [2:0] S_MSS    = 3'd3;
    localparam logic [2:0] S_RUN    = 3'd4;
    localparam logic [2:0] S_FAULT  = 3'd5;

    localparam int MAXC = LOCK_STABLE_CYCLES > MSS_TIMEOUT_CYCLES ? LOCK_STABLE_CYCLES : MSS_TIMEOUT_CYCLES;
    localparam int CW   = MAXC > 1 ? $clog2(MAXC) : 1;

    logic [SYNC_STAGES-1:0] init_sync_q, lock_sync_q, m2f_sync_q;
    logic                   init_done_s, pll_lock_s, mss_n_m2f_s;
    logic [2:0]             state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   f2m_q, f2m_d, frn_q, frn_d, en_q, en_d, fault_q, fault_d;
    logic [7:0]             rc_q, rc_d;
    logic                   lock_done, mss_timeout;

    assign init_done_s = init_sync_q[SYNC_STAGES-1];
    assign pll_lock_s  = lock_sync_q[SYNC_STAGES-1];
    assign mss_n_m2f_s = m2f_sync_q[SYNC_STAGES-1];
    assign lock_done   = cnt_q == CW'(LOCK_STABLE_CYCLES - 1);
    assign mss_timeout = cnt_q == CW'(MSS_TIMEOUT_CYCLES - 1);

    always_ff @(posedge clkin or negedge resetn) begin
        if (!resetn) begin
            init_sync_q <= '0;
            lock_sync_q <= '0;
            m2f_sync_q  <= '0;
        end else begin
            init_sync_q <= {init_sync_q[SYNC_STAGES-2:0], device_init_done};
            lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], pll_lock};
            m2f_sync_q  <= {m2f_sync_q[SYNC_STAGES-2:0], mss_reset_n_m2f};
        end
    end

    always_ff @(posedge clkin or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_INIT;
            cnt_q   <= '0;
            f2m_q   <= 1'b0;
            frn_q   <= 1'b0;
            en_q    <= 1'b0;
            fault_q <= 1'b0;
            rc_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            f2m_q   <= f2m_d;
            frn_q   <= frn_d;
            en_q    <= en_d;
            fault_q <= fault_d;
            rc_q    <= rc_d;
        end
    end

    // Lock loss outranks every other exit; S_FAULT is absorbing until resetn.
    always_comb begin
        state_d = S_INIT;
        case (state_q)
            S_INIT:   state_d = init_done_s ? S_LOCK : S_INIT;
            S_LOCK:   state_d = pll_lock_s ? S_STABLE : S_LOCK;
            S_STABLE: state_d = !pll_lock_s ? S_LOCK : lock_done ? S_MSS : S_STABLE;
            S_MSS:    state_d = !pll_lock_s ? S_LOCK : mss_n_m2f_s ? S_RUN : mss_timeout ? S_FAULT : S_MSS;
            S_RUN:    state_d = !pll_lock_s ? S_LOCK : !mss_n_m2f_s ? S_MSS : S_RUN;
            S_FAULT:  state_d = S_FAULT;
            default:  state_d = S_INIT;
        endcase
    end

    // Outputs are computed from the next state so they change on the entry edge.
    always_comb begin
        cnt_d   = (state_d == state_q && (state_q == S_STABLE || state_q == S_MSS)) ? cnt_q + CW'(1) : '0;
        f2m_d   = state_d == S_FAULT ? 1'b0 : state_d == S_MSS ? 1'b1 : f2m_q;
        frn_d   = state_d == S_RUN;
        en_d    = state_d == S_RUN;
        fault_d = state_d == S_FAULT;
        rc_d    = (state_q == S_RUN && state_d != S_RUN && rc_q != 8'hFF) ? rc_q + 8'd1 : rc_q;
    end

    assign state           = state_q;
    assign mss_reset_n_f2m = f2m_q;
    assign fabric_resetn   = frn_q;
    assign enable          = en_q;
    assign fault           = fault_q;
    assign relock_count    = rc_q;

endmodule

// File: tb/tb_fabric_bringup_seq.sv
// tb_fabric_bringup_seq: directed bring-up scenarios; expected output changes are queued
// with their edge number and a monitor pops one entry per observed output change.
module tb_fabric_bringup_seq;

    localparam int L = 8;
    localparam int T = 16;

    logic       clk, resetn, init_done, lock, m2f;
    logic       f2m, frn, en, flt;
    logic [2:0] st;
    logic [7:0] rc;

    typedef struct {
        int          c;
        logic [13:0] v;
        string       name;
    } exp_t;

    exp_t        q[$];
    exp_t        e;
    int          cyc, checks, failures, b, j, rc_exp;
    logic [13:0] cur, prev;
    bit          first;

    fabric_bringup_seq #(
        .SYNC_STAGES(2),
        .LOCK_STABLE_CYCLES(L),
        .MSS_TIMEOUT_CYCLES(T)
    ) dut (
        .clkin(clk),
        .resetn(resetn),
        .device_init_done(init_done),
        .pll_lock(lock),
        .mss_reset_n_m2f(m2f),
        .mss_reset_n_f2m(f2m),
        .fabric_resetn(frn),
        .enable(en),
        .state(st),
        .fault(flt),
        .relock_count(rc)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    task automatic push(input int c, input logic [2:0] s, input logic f, input logic r,
                        input logic n, input logic t, input logic [7:0] k, input string name);
        exp_t x;
        x.c = c;
        x.v = {s, f, r, n, t, k};
        x.name = name;
        q.push_back(x);
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic relock();
        j = cyc;
        lock = 0;
        rc_exp = rc_exp == 255 ? 255 : rc_exp + 1;
        push(j + 3, 1, 1, 0, 0, 0, 8'(rc_exp), "run_lock_loss");
        push(j + 6, 2, 1, 0, 0, 0, 8'(rc_exp), "relock_stable");
        push(j + 6 + L, 3, 1, 0, 0, 0, 8'(rc_exp), "relock_mss");
        push(j + 7 + L, 4, 1, 1, 1, 0, 8'(rc_exp), "relock_run");
        wait_cyc(j + 3);
        lock = 1;
        wait_cyc(j + 9 + L);
    endtask

    initial begin
        first = 1;
        prev = '0;
        forever begin
            @(negedge clk or negedge resetn);
            #1;
            cur = {st, f2m, frn, en, flt, rc};
            if (first || cur !== prev) begin
                first = 0;
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_change cyc=%0d outputs got=%h", cyc, cur);
                end else begin
                    e = q.pop_front();
                    if (e.v !== cur || e.c != cyc)
                        begin
                            failures++;
                            $display("FAIL %s edge got=%0d want=%0d outputs got=%h want=%h",
                                     e.name, cyc, e.c, cur, e.v);
                        end
                end
            end
            prev = cur;
        end
    end

    initial begin
        checks = 0;
        failures = 0;
        rc_exp = 0;
        resetn = 1;
        init_done = 0;
        lock = 0;
        m2f = 0;
        push(0, 0, 0, 0, 0, 0, 0, "reset_state");
        #1 resetn = 0;
        init_done = 1;
        lock = 1;
        repeat (3) @(negedge clk);
        resetn = 1;
        b = cyc;
        // nominal bring-up with a one-cycle lock glitch inside S_STABLE
        push(b + 3, 1, 0, 0, 0, 0, 0, "init_to_lock");
        push(b + 4, 2, 0, 0, 0, 0, 0, "lock_to_stable");
        wait_cyc(b + 6);
        lock = 0;
        @(negedge clk);
        lock = 1;
        push(b + 9, 1, 0, 0, 0, 0, 0, "glitch_to_lock");
        push(b + 10, 2, 0, 0, 0, 0, 0, "glitch_restable");
        push(b + 10 + L, 3, 1, 0, 0, 0, 0, "mss_release");
        wait_cyc(b + 20 + L);
        m2f = 1;
        push(b + 23 + L, 4, 1, 1, 1, 0, 0, "first_run");
        wait_cyc(b + 26 + L);
        relock();
        // MSS reset while running
        j = cyc;
        m2f = 0;
        rc_exp = rc_exp + 1;
        push(j + 3, 3, 1, 0, 0, 0, 8'(rc_exp), "mss_reset_from_run");
        wait_cyc(j + 5);
        m2f = 1;
        push(j + 8, 4, 1, 1, 1, 0, 8'(rc_exp), "mss_back_to_run");
        wait_cyc(j + 10);
        repeat (298) relock();
        // async reset in S_MSS, then MSS timeout on the next bring-up
        j = cyc;
        m2f = 0;
        push(j + 3, 3, 1, 0, 0, 0, 8'd255, "mss_reset_saturated");
        wait_cyc(j + 5);
        @(posedge clk);
        #1;
        push(cyc, 0, 0, 0, 0, 0, 0, "async_reset_mid_mss");
        resetn = 0;
        @(negedge clk);
        resetn = 1;
        b = cyc;
        push(b + 3, 1, 0, 0, 0, 0, 0, "restart_lock");
        push(b + 4, 2, 0, 0, 0, 0, 0, "restart_stable");
        push(b + 4 + L, 3, 1, 0, 0, 0, 0, "restart_mss");
        push(b + 4 + L + T, 5, 0, 0, 0, 1, 0, "mss_timeout_fault");
        wait_cyc(b + 8 + L + T);
        for (int i = 0; i < 8; i++) begin
            lock = ~lock;
            m2f = ~m2f;
            @(negedge clk);
        end
        init_done = 0;
        repeat (5) @(negedge clk);
        @(posedge clk);
        #1;
        push(cyc, 0, 0, 0, 0, 0, 0, "fault_cleared_by_reset");
        resetn = 0;
        @(negedge clk);
        resetn = 1;
        repeat (20) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain pending got=%0d want=0 next=%s", q.size(), q[0].name);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
